// File: rtl/apb_pkg.sv
// apb_pkg: shared state type and address
// decode helpers for the APB4 memory completer.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int CNT_W = $clog2(16);

  function automatic int bytes_per_word(
    input int dw
  );
    return dw / 8;
  endfunction

  function automatic int word_lsb(
    input int dw
  );
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// apb4_mem_slave_if: APB4 completer-side bus
// bundle with requester and completer views.
interface apb4_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic                    pslverr;
  logic [DATA_WIDTH-1:0]   prdata;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    output pstrb,
    output pprot,
    input  pready,
    input  pslverr,
    input  prdata
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    input  pstrb,
    input  pprot,
    output pready,
    output pslverr,
    output prdata
  );

endinterface

// File: rtl/apb_mem_array.sv
// apb_mem_array: word RAM with byte-enable
// synchronous write and combinational read.
module apb_mem_array #(
  parameter int  DATA_WIDTH = 32,
  parameter int  MEM_DEPTH  = 256,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         wstrb,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Update only the lanes selected by the strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave: APB4 completer in front of a
// word RAM, with wait states and error decode.
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 32'h0000_1000,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int RO_DEPTH    = 0
) (
  input logic clk,
  input logic rst_n,
  apb4_mem_slave_if.slave bus
);

  localparam int BYTES_PER_WORD =
    bytes_per_word(DATA_WIDTH);
  localparam int WORD_LSB = word_lsb(DATA_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(MEM_DEPTH * BYTES_PER_WORD);

  apb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic setup;

  logic [ADDR_WIDTH-1:0] off;
  logic below, oor, mis, prot, err;
  logic [IDX_W-1:0] idx;

  logic                      err_q;
  logic                      wr_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [BYTES_PER_WORD-1:0] strb_q;
  logic [DATA_WIDTH-1:0]     prdata_q;

  logic                  pready;
  logic                  we;
  logic [DATA_WIDTH-1:0] rd;
  logic                  unused_ok;

  assign off   = bus.paddr - BASE;
  assign below = bus.paddr < BASE;
  assign oor   = below | (off >= SPAN);
  assign mis   = |off[WORD_LSB-1:0];
  assign idx   = off[WORD_LSB +: IDX_W];

  if (RO_DEPTH > 0) begin : g_ro
    logic [ADDR_WIDTH-1:0] woff;
    assign woff = off >> WORD_LSB;
    assign prot = bus.pwrite &
      (woff < ADDR_WIDTH'(RO_DEPTH));
  end else begin : g_no_ro
    assign prot = 1'b0;
  end

  assign err = oor | mis | prot;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down the wait, abort if
  // the requester lets go of psel early.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (!bus.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the decoded request and read word
  // at setup; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else if (setup) begin
      err_q    <= err;
      wr_q     <= bus.pwrite;
      idx_q    <= idx;
      wdata_q  <= bus.pwdata;
      strb_q   <= bus.pstrb;
      prdata_q <= err ? '0 : rd;
    end
  end

  assign pready = (state_q == ACCESS) &&
                  (cnt_q == '0);
  assign we     = pready & wr_q & ~err_q;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (idx),
    .rdata (rd)
  );

  assign bus.pready  = pready;
  assign bus.pslverr = pready & err_q;
  assign bus.prdata  = prdata_q;

  assign unused_ok = ^bus.pprot;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb_apb4_mem_slave: directed table, corner
// sequences and a random run against a model.
module tb_apb4_mem_slave;
  import apb_pkg::*;

  localparam logic [31:0] BASE = 32'h1000;
  localparam int DEPTH = 64;
  localparam int RO = 4;

  logic clk;
  logic rst2_n;
  logic rst0_n;
  int checks;
  int errors;

  apb4_mem_slave_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) b2 ();
  apb4_mem_slave_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) b0 ();

  apb4_mem_slave #(
    .BASE_ADDR(32'h1000), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
    .WAIT_CYCLES(2), .RO_DEPTH(RO)
  ) d2 (
    .clk(clk), .rst_n(rst2_n), .bus(b2.slave)
  );

  apb4_mem_slave #(
    .BASE_ADDR(32'h1000), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
    .WAIT_CYCLES(0), .RO_DEPTH(RO)
  ) d0 (
    .clk(clk), .rst_n(rst0_n), .bus(b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } vec_t;

  vec_t tv [18];
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, got, exp);
    end
  endtask

  function automatic logic ref_err(
    input logic wr, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= DEPTH * 4) return 1'b1;
    if (off % 4 != 0) return 1'b1;
    if (wr && (off / 4) < RO) return 1'b1;
    return 1'b0;
  endfunction

  task automatic xfer2(input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] st,
                       output logic [31:0] rd,
                       output logic er,
                       output int lat);
    @(posedge clk); #1;
    b2.psel = 1'b1;
    b2.penable = 1'b0;
    b2.pwrite = wr;
    b2.paddr = a;
    b2.pwdata = d;
    b2.pstrb = st;
    lat = 0;
    rd = '0;
    er = 1'b0;
    @(posedge clk); #1;
    b2.penable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b2.pready) begin
        lat = n;
        rd = b2.prdata;
        er = b2.pslverr;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle2();
    @(posedge clk); #1;
    b2.psel = 1'b0;
    b2.penable = 1'b0;
  endtask

  task automatic xfer0(input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output logic [31:0] rd,
                       output logic p_set,
                       output logic p_acc,
                       output logic er);
    @(posedge clk); #1;
    b0.psel = 1'b1;
    b0.penable = 1'b0;
    b0.pwrite = wr;
    b0.paddr = a;
    b0.pwdata = d;
    b0.pstrb = 4'hF;
    @(negedge clk);
    p_set = b0.pready;
    @(posedge clk); #1;
    b0.penable = 1'b1;
    @(negedge clk);
    p_acc = b0.pready;
    rd = b0.prdata;
    er = b0.pslverr;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        ps, pa;
  logic [31:0] vals [4];

  initial begin
    checks = 0;
    errors = 0;
    rst2_n = 1'b0;
    rst0_n = 1'b0;
    b2.psel = 0; b2.penable = 0; b2.pwrite = 0;
    b2.paddr = 0; b2.pwdata = 0; b2.pstrb = 0;
    b2.pprot = 0;
    b0.psel = 0; b0.penable = 0; b0.pwrite = 0;
    b0.paddr = 0; b0.pwdata = 0; b0.pstrb = 0;
    b0.pprot = 0;

    tv[0]  = '{1'b1, 32'h1010, 32'hDEADBEEF,
               4'hF, 32'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 32'h1010, 32'h0,
               4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 32'h1014, 32'hAAAAAAAA,
               4'hF, 32'h0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 32'h1014, 32'h11223344,
               4'b0101, 32'h0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 32'h1014, 32'h0,
               4'h0, 32'hAA22AA44, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 32'h1004, 32'h12345678,
               4'hF, 32'h0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 32'h1100, 32'h0,
               4'h0, 32'h0, 1'b1, 1'b1};
    tv[7]  = '{1'b0, 32'h0FFC, 32'h0,
               4'h0, 32'h0, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 32'h1012, 32'hCAFEF00D,
               4'hF, 32'h0, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 32'h1010, 32'h0,
               4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[10] = '{1'b1, 32'h1010, 32'hFFFFFFFF,
               4'h0, 32'h0, 1'b0, 1'b0};
    tv[11] = '{1'b0, 32'h1010, 32'h0,
               4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[12] = '{1'b1, 32'h10FC, 32'h0BADC0DE,
               4'hF, 32'h0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 32'h10FC, 32'h0,
               4'h0, 32'h0BADC0DE, 1'b0, 1'b1};
    tv[14] = '{1'b0, 32'h1000, 32'h0,
               4'h0, 32'h0, 1'b0, 1'b0};
    tv[15] = '{1'b1, 32'h1000, 32'h0,
               4'hF, 32'h0, 1'b1, 1'b0};
    tv[16] = '{1'b1, 32'h100C, 32'h0,
               4'hF, 32'h0, 1'b1, 1'b0};
    tv[17] = '{1'b0, 32'h1013, 32'h0,
               4'h0, 32'h0, 1'b1, 1'b1};

    // reset state
    #12;
    chk("rst_pready2", 32'(b2.pready), 32'h0);
    chk("rst_pslverr2", 32'(b2.pslverr), 32'h0);
    chk("rst_prdata2", b2.prdata, 32'h0);
    chk("rst_pready0", 32'(b0.pready), 32'h0);
    chk("rst_prdata0", b0.prdata, 32'h0);
    @(posedge clk); #1;
    rst2_n = 1'b1;
    rst0_n = 1'b1;

    // directed table
    for (int i = 0; i < 18; i++) begin
      xfer2(tv[i].wr, tv[i].addr, tv[i].wdata,
            tv[i].strb, rd, er, lat);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_err", i),
          32'(er), 32'(tv[i].err));
      if (tv[i].chk)
        chk($sformatf("vec%0d_rdata", i),
            rd, tv[i].rdata);
    end
    idle2();

    // reset during the wait phase
    xfer2(1'b1, 32'h1020, 32'h01010101, 4'hF,
          rd, er, lat);
    chk("rw_pre_err", 32'(er), 32'h0);
    idle2();
    @(posedge clk); #1;
    b2.psel = 1'b1; b2.penable = 1'b0;
    b2.pwrite = 1'b1; b2.paddr = 32'h1020;
    b2.pwdata = 32'hFFFFFFFF; b2.pstrb = 4'hF;
    @(posedge clk); #1;
    b2.penable = 1'b1;
    @(negedge clk); #1;
    rst2_n = 1'b0;
    #1;
    chk("rw_pready", 32'(b2.pready), 32'h0);
    chk("rw_pslverr", 32'(b2.pslverr), 32'h0);
    chk("rw_state", 32'(d2.state_q), 32'(IDLE));
    b2.psel = 1'b0; b2.penable = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    xfer2(1'b0, 32'h1020, 32'h0, 4'h0,
          rd, er, lat);
    chk("rw_read", rd, 32'h01010101);
    chk("rw_read_lat", lat, 3);

    // reset inside the pready cycle of a write
    xfer2(1'b1, 32'h1024, 32'h02020202, 4'hF,
          rd, er, lat);
    xfer2(1'b1, 32'h1024, 32'hFFFFFFFF, 4'hF,
          rd, er, lat);
    chk("rp_lat", lat, 3);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("rp_pready", 32'(b2.pready), 32'h0);
    b2.psel = 1'b0; b2.penable = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    xfer2(1'b0, 32'h1024, 32'h0, 4'h0,
          rd, er, lat);
    chk("rp_read", rd, 32'h02020202);

    // reset inside an error response
    xfer2(1'b1, 32'h1004, 32'h0, 4'hF,
          rd, er, lat);
    chk("re_err", 32'(er), 32'h1);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("re_pready", 32'(b2.pready), 32'h0);
    chk("re_pslverr", 32'(b2.pslverr), 32'h0);
    b2.psel = 1'b0; b2.penable = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;

    // psel dropped during the wait
    xfer2(1'b1, 32'h1028, 32'h66666666, 4'hF,
          rd, er, lat);
    idle2();
    @(posedge clk); #1;
    b2.psel = 1'b1; b2.penable = 1'b0;
    b2.pwrite = 1'b1; b2.paddr = 32'h1028;
    b2.pwdata = 32'h77777777; b2.pstrb = 4'hF;
    @(posedge clk); #1;
    b2.penable = 1'b1;
    @(negedge clk);
    chk("ab_pready1", 32'(b2.pready), 32'h0);
    @(posedge clk); #1;
    b2.psel = 1'b0; b2.penable = 1'b0;
    @(negedge clk);
    chk("ab_pready2", 32'(b2.pready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_pready3", 32'(b2.pready), 32'h0);
    chk("ab_state", 32'(d2.state_q), 32'(IDLE));
    xfer2(1'b0, 32'h1028, 32'h0, 4'h0,
          rd, er, lat);
    chk("ab_read", rd, 32'h66666666);
    chk("ab_lat", lat, 3);
    idle2();

    // zero-wait back-to-back pairs
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      xfer0(1'b1, 32'h1040 + 32'(4 * i), vals[i],
            rd, ps, pa, er);
      chk("z_w_setup", 32'(ps), 32'h0);
      chk("z_w_acc", 32'(pa), 32'h1);
      chk("z_w_err", 32'(er), 32'h0);
      xfer0(1'b0, 32'h1040 + 32'(4 * i), 32'h0,
            rd, ps, pa, er);
      chk("z_r_setup", 32'(ps), 32'h0);
      chk("z_r_acc", 32'(pa), 32'h1);
      chk("z_r_data", rd, vals[i]);
    end
    @(posedge clk); #1;
    b0.psel = 1'b0; b0.penable = 1'b0;

    // random run against the model
    for (int w = RO; w < DEPTH; w++) begin
      ref_mem[w] = $urandom;
      xfer2(1'b1, BASE + 32'(4 * w), ref_mem[w],
            4'hF, rd, er, lat);
      chk("init_err", 32'(er), 32'h0);
    end
    for (int k = 0; k < 200; k++) begin
      logic        wr, eerr;
      logic [31:0] a, d;
      logic [3:0]  st;
      int          sel, w;
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      st  = 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        a = BASE + $urandom_range(0, 255);
      else if (sel == 1)
        a = 32'h1100 + 4 * $urandom_range(0, 63);
      else if (sel == 2)
        a = 32'h0F00 + 4 * $urandom_range(0, 63);
      else
        a = BASE + 4 * $urandom_range(0, 63);
      eerr = ref_err(wr, a);
      w = int'((a - BASE) >> 2);
      xfer2(wr, a, d, st, rd, er, lat);
      chk("rnd_lat", lat, 3);
      chk("rnd_err", 32'(er), 32'(eerr));
      if (!wr && eerr)
        chk("rnd_rd_err0", rd, 32'h0);
      if (!wr && !eerr && w >= RO)
        chk("rnd_rdata", rd, ref_mem[w]);
      if (wr && !eerr)
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    end
    idle2();

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 completer fronting an on-chip word memory, replacing the fixed-width single-wait slave in the APB bridge subsystem. Adds byte-strobe writes, a relocatable base address, configurable wait states, and a write-protected region. Full error signalling covers out-of-range, misaligned and protected-write accesses. Sits downstream of the APB bridge master on the peripheral-side bus.

## Interface
- BASE_ADDR, 32'h0000_1000, byte address of memory word 0; aligned to DATA_WIDTH/8
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, bus and word width; 32 or 64
- MEM_DEPTH, 256, number of words; power of two, ≥4
- WAIT_CYCLES, 1, wait states inserted per transfer; 0..15
- RO_DEPTH, 0, words [0, RO_DEPTH) are write-protected; 0 disables protection
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write byte lanes; ignored on reads
- pprot  in  3  accepted, unused
- pready  out  1  transfer completion
- pslverr  out  1  error response; valid only while pready=1, else 0
- prdata  out  DATA_WIDTH  read data; valid while pready=1

## Operation
- Reset values: pready=0, pslverr=0, prdata=0, state IDLE, wait counter 0. Memory contents are not reset; they are undefined until written.
- FSM has 2 states:
  - IDLE: on psel & ~penable (setup), decode the address, latch the error flag and read word, load counter=WAIT_CYCLES, then go to ACCESS.
  - ACCESS: counter decrements while nonzero. pready = (state==ACCESS) & (counter==0). In the pready cycle, return to IDLE.
- Decode:
  - offset = paddr − BASE_ADDR.
  - out-of-range if paddr < BASE_ADDR or offset ≥ MEM_DEPTH·DATA_WIDTH/8.
  - misaligned if offset[log2(DATA_WIDTH/8)−1:0] ≠ 0.
  - protected if pwrite=1 and word index < RO_DEPTH.
  - Any of these sets err.
- Write: committed only in the pready cycle with err=0. For each lane b with pstrb[b]=1, mem[idx][8b+7:8b] ← pwdata byte b. A write with pstrb all zero is legal and changes nothing.
- Read: prdata ← mem[idx], registered at setup; prdata=0 when err=1.
- Error: pready=1, pslverr=1, no memory update.
- Protocol violation: if psel drops in ACCESS before pready, abort the transfer. Return to IDLE with no write and no pready.
- prdata holds its last value in IDLE; software must not sample it then.

## Timing
- Setup in cycle T puts the FSM in ACCESS at T+1. pready asserts at T+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives a zero-wait transfer of 2 cycles.
- pready and pslverr are decoded from registers only; there is no combinational path from APB inputs.
- Back-to-back: a new setup in the cycle after pready is accepted from IDLE with no dead cycle.
- Address and control are sampled at setup and are required stable through the access phase (APB rule). Later changes are ignored.
- Reset mid-transfer drops pready and pslverr immediately (asynchronously). The memory write is not performed.

## Structure
- Package apb_pkg holds:
  - state enum (IDLE, ACCESS)
  - address-decode helper constants: BYTES_PER_WORD, WORD_LSB, counter width $clog2(16)
- Sub-module apb_mem_array holds the byte-enable synchronous-write, combinational-read word RAM. It is parametrised on DATA_WIDTH and MEM_DEPTH, so it can later be swapped for a macro.

## Test plan
- Config is BASE_ADDR=0x1000, DATA_WIDTH=32, MEM_DEPTH=64, WAIT_CYCLES=2, RO_DEPTH=4 unless stated.
- Write 0xDEADBEEF to 0x1010 with pstrb=4'hF, then read 0x1010. Each transfer completes with pready 3 cycles after setup and pslverr=0; the read returns prdata=0xDEADBEEF.
- Write 0x11223344 to 0x1014 with pstrb=4'b0101 over prior 0xAAAAAAAA. A read returns 0xAA22AA44.
- Error cases, each giving pready + pslverr=1 and no memory change:
  - write to 0x1004 (protected)
  - read of 0x1100 (out of range)
  - read of 0x0FFC (below base)
  - write to 0x1012 (misaligned)
- Rerun with WAIT_CYCLES=0: back-to-back read/write pairs complete every 2 cycles, with pready high only in each access cycle.
- Assert rst_n=0 during the wait phase of a write to 0x1020. pready and pslverr go to 0 at once; a read after reset shows the word was not written.
- Drop psel mid-wait: no pready is issued, the FSM is in IDLE the next cycle, and the following legal transfer completes normally.
